cp0_regfile: RTL

Coprocessor-0 register file and exception commit unit for the 5-stage MIPS pipeline. It is the consumer of the CP0 address, `mtc0` write-enable and exception code/flag that the decode stage attaches to each instruction. It sits beside the write-back stage, where it does the following:
- serves `mfc0` reads;
- commits `mtc0` writes;
- records exceptions (EPC, Cause, BadVAddr, Status.EXL) and handles `eret`;
- runs the Count/Compare timer and raises the interrupt request.

---
 rtl/cp0_regfile.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file and exception commit unit for the 5-stage MIPS pipeline.
// Serves mfc0 reads, commits mtc0/eret/exceptions at write-back and runs the Count/Compare timer.
module cp0_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic        wb_ex,
  input  logic [4:0]  wb_excode,
  input  logic        wb_bd,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badvaddr,
  input  logic        eret,
  input  logic [5:0]  ext_int_in,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic        has_int
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  logic [31:0] badvaddr_reg;
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic [31:0] epc_reg;
  logic [7:0]  status_im_reg;
  logic        status_exl_reg;
  logic        status_ie_reg;
  logic        cause_bd_reg;
  logic        cause_ti_reg;
  logic [4:0]  cause_excode_reg;
  logic [5:0]  ext_int_reg;
  logic [1:0]  cause_ip_sw_reg;
  logic        tick_reg;

  logic ex_fire;
  logic eret_fire;
  logic mtc0_fire;

  // An exception in write-back wins over any eret/mtc0 carried by the same instruction.
  assign ex_fire   = wb_valid & wb_ex;
  assign eret_fire = wb_valid & eret & ~wb_ex;
  assign mtc0_fire = wb_valid & mtc0_we & ~wb_ex;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      badvaddr_reg     <= '0;
      count_reg        <= '0;
      compare_reg      <= '0;
      epc_reg          <= '0;
      status_im_reg    <= '0;
      status_exl_reg   <= 1'b0;
      status_ie_reg    <= 1'b0;
      cause_bd_reg     <= 1'b0;
      cause_ti_reg     <= 1'b0;
      cause_excode_reg <= '0;
      ext_int_reg      <= '0;
      cause_ip_sw_reg  <= '0;
      tick_reg         <= 1'b0;
    end else begin
      tick_reg    <= ~tick_reg;
      ext_int_reg <= ext_int_in;

      if (mtc0_fire && cp0_addr == ADDR_COUNT) begin
        count_reg <= cp0_wdata;
      end else if (tick_reg) begin
        count_reg <= count_reg + 32'd1;
      end

      if (mtc0_fire && cp0_addr == ADDR_COMPARE) begin
        compare_reg  <= cp0_wdata;
        cause_ti_reg <= 1'b0;
      end else if (count_reg == compare_reg) begin
        cause_ti_reg <= 1'b1;
      end

      if (ex_fire) begin
        status_exl_reg   <= 1'b1;
        cause_excode_reg <= wb_excode;
        // A nested exception keeps the original return point.
        if (!status_exl_reg) begin
          epc_reg      <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
          cause_bd_reg <= wb_bd;
        end
        if (wb_excode == EXC_ADEL || wb_excode == EXC_ADES) begin
          badvaddr_reg <= wb_badvaddr;
        end
      end else if (eret_fire) begin
        status_exl_reg <= 1'b0;
      end else if (mtc0_fire) begin
        case (cp0_addr)
          ADDR_STATUS: begin
            status_im_reg  <= cp0_wdata[15:8];
            status_exl_reg <= cp0_wdata[1];
            status_ie_reg  <= cp0_wdata[0];
          end
          ADDR_CAUSE: cause_ip_sw_reg <= cp0_wdata[9:8];
          ADDR_EPC:   epc_reg <= cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  // IP7 shares the top hardware line with the timer flag.
  assign cp0_status = {9'b0, 1'b1, 6'b0, status_im_reg, 6'b0, status_exl_reg, status_ie_reg};
  assign cp0_cause  = {cause_bd_reg, cause_ti_reg, 14'b0,
                       ext_int_reg[5] | cause_ti_reg, ext_int_reg[4:0],
                       cause_ip_sw_reg, 1'b0, cause_excode_reg, 2'b0};
  assign cp0_epc    = epc_reg;
  assign has_int    = (|(cp0_cause[15:8] & status_im_reg)) & status_ie_reg & ~status_exl_reg;

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr_reg;
      ADDR_COUNT:    cp0_rdata = count_reg;
      ADDR_COMPARE:  cp0_rdata = compare_reg;
      ADDR_STATUS:   cp0_rdata = cp0_status;
      ADDR_CAUSE:    cp0_rdata = cp0_cause;
      ADDR_EPC:      cp0_rdata = epc_reg;
      default:       cp0_rdata = 32'd0;
    endcase
  end

endmodule
